// File: rtl/aq_rtu_wb_arb.sv
// Writeback arbiter for the register-file write ports.
// Port0 carries the registered rbus result, port1 carries the LSU result.
// Backpressured requesters fill whichever port is idle using a round-robin
// search, and a starvation counter raises rbus_stall when they wait too long.
module aq_rtu_wb_arb #(
   parameter int DATA_W       = 64,
   parameter int PREG_W       = 6,
   parameter int NUM_REQ      = 4,
   parameter int DUAL_PORT    = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                      wb_clk,
   input  logic                      cpurst_b,
   input  logic                      rbus_wb_vld,
   input  logic [PREG_W-1:0]         rbus_wb_preg,
   input  logic [DATA_W-1:0]         rbus_wb_data,
   input  logic                      lsu_wb_vld,
   input  logic [PREG_W-1:0]         lsu_wb_preg,
   input  logic [DATA_W-1:0]         lsu_wb_data,
   input  logic [NUM_REQ-1:0]        req_vld,
   input  logic [NUM_REQ*PREG_W-1:0] req_preg,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_grnt,
   output logic                      wb0_vld,
   output logic [PREG_W-1:0]         wb0_preg,
   output logic [DATA_W-1:0]         wb0_data,
   output logic                      wb1_vld,
   output logic [PREG_W-1:0]         wb1_preg,
   output logic [DATA_W-1:0]         wb1_data,
   output logic                      rbus_stall,
   output logic                      wb_no_op
);

   localparam int         PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam bit         USE_P1 = (DUAL_PORT != 0) && (NUM_REQ > 1);
   localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

   logic               r_rbus_vld;
   logic [PREG_W-1:0]  r_rbus_preg;
   logic [DATA_W-1:0]  r_rbus_data;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [7:0]         r_starve_cnt;
   logic               r_stall;

   logic               w_hit0, w_hit1;
   logic [PTR_W-1:0]   w_idx0, w_idx1;
   logic               w_p0_free, w_p1_free;
   logic               w_p0_gnt, w_p1_gnt;
   logic [PTR_W-1:0]   w_p0_idx, w_p1_idx;
   logic [PTR_W-1:0]   w_last;
   logic [PTR_W-1:0]   w_ptr_nxt;
   logic [NUM_REQ-1:0] w_grnt;
   logic               w_any_req, w_any_gnt;

   // Find the first and second asserted requests searching upward from rr_ptr.
   always_comb begin
      w_hit0 = 1'b0;
      w_hit1 = 1'b0;
      w_idx0 = '0;
      w_idx1 = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         logic [PTR_W-1:0] w_scan;
         w_scan = PTR_W'((32'(r_rr_ptr) + k) % 32'(NUM_REQ));
         if (req_vld[w_scan]) begin
            if (!w_hit0) begin
               w_hit0 = 1'b1;
               w_idx0 = w_scan;
            end else if (!w_hit1) begin
               w_hit1 = 1'b1;
               w_idx1 = w_scan;
            end
         end
      end
   end

   // Map the search results onto the free ports; grants are held off in reset.
   always_comb begin
      w_p0_free = !r_rbus_vld;
      w_p1_free = USE_P1 && !lsu_wb_vld;
      w_p0_gnt  = cpurst_b && w_p0_free && w_hit0;
      w_p0_idx  = w_idx0;
      if (w_p0_free) begin
         w_p1_gnt = cpurst_b && w_p1_free && w_hit1;
         w_p1_idx = w_idx1;
      end else begin
         w_p1_gnt = cpurst_b && w_p1_free && w_hit0;
         w_p1_idx = w_idx0;
      end
      w_grnt = '0;
      if (w_p0_gnt) w_grnt[w_p0_idx] = 1'b1;
      if (w_p1_gnt) w_grnt[w_p1_idx] = 1'b1;
      // port1 always sits later in search order, so it is the last granted
      w_last    = w_p1_gnt ? w_p1_idx : w_p0_idx;
      w_ptr_nxt = PTR_W'((32'(w_last) + 32'd1) % 32'(NUM_REQ));
      w_any_req = |req_vld;
      w_any_gnt = w_p0_gnt || w_p1_gnt;
   end

   // rbus valid stage, discarded on reset.
   always_ff @(posedge wb_clk or negedge cpurst_b) begin
      if (!cpurst_b) r_rbus_vld <= 1'b0;
      else           r_rbus_vld <= rbus_wb_vld;
   end

   // rbus payload, captured only with a valid result.
   always_ff @(posedge wb_clk) begin
      if (rbus_wb_vld) begin
         r_rbus_preg <= rbus_wb_preg;
         r_rbus_data <= rbus_wb_data;
      end
   end

   // Round-robin pointer advances past the last granted requester.
   always_ff @(posedge wb_clk or negedge cpurst_b) begin
      if (!cpurst_b)      r_rr_ptr <= '0;
      else if (w_any_gnt) r_rr_ptr <= w_ptr_nxt;
   end

   // Starvation counter and the stall request it raises once saturated.
   always_ff @(posedge wb_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_starve_cnt <= '0;
         r_stall      <= 1'b0;
      end else if (w_any_gnt || !w_any_req) begin
         r_starve_cnt <= '0;
         r_stall      <= 1'b0;
      end else begin
         if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 8'd1;
         else                       r_stall      <= 1'b1;
      end
   end

   assign req_grnt   = w_grnt;
   assign wb0_vld    = r_rbus_vld || w_p0_gnt;
   assign wb0_preg   = r_rbus_vld ? r_rbus_preg : req_preg[w_p0_idx*PREG_W +: PREG_W];
   assign wb0_data   = r_rbus_vld ? r_rbus_data : req_data[w_p0_idx*DATA_W +: DATA_W];
   assign wb1_vld    = lsu_wb_vld || w_p1_gnt;
   assign wb1_preg   = lsu_wb_vld ? lsu_wb_preg : req_preg[w_p1_idx*PREG_W +: PREG_W];
   assign wb1_data   = lsu_wb_vld ? lsu_wb_data : req_data[w_p1_idx*DATA_W +: DATA_W];
   assign rbus_stall = r_stall;
   assign wb_no_op   = !wb0_vld && !wb1_vld;

endmodule

// File: tb/tb_aq_rtu_wb_arb.sv
// Bench for aq_rtu_wb_arb: directed vectors with literal expectations plus
// a per-cycle comparison against a queue-based writeback model.
module tb_aq_rtu_wb_arb;

   localparam int DW  = 64;
   localparam int PW  = 6;
   localparam int NR  = 4;
   localparam int LIM = 8;

   logic              wb_clk = 1'b0;
   logic              cpurst_b;
   logic              rbus_wb_vld;
   logic [PW-1:0]     rbus_wb_preg;
   logic [DW-1:0]     rbus_wb_data;
   logic              lsu_wb_vld;
   logic [PW-1:0]     lsu_wb_preg;
   logic [DW-1:0]     lsu_wb_data;
   logic [NR-1:0]     req_vld;
   logic [NR*PW-1:0]  req_preg;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_grnt;
   logic              wb0_vld, wb1_vld;
   logic [PW-1:0]     wb0_preg, wb1_preg;
   logic [DW-1:0]     wb0_data, wb1_data;
   logic              rbus_stall, wb_no_op;

   always #5 wb_clk = ~wb_clk;

   aq_rtu_wb_arb #(
      .DATA_W(DW), .PREG_W(PW), .NUM_REQ(NR), .DUAL_PORT(1), .STARVE_LIMIT(LIM)
   ) dut (
      .wb_clk(wb_clk), .cpurst_b(cpurst_b),
      .rbus_wb_vld(rbus_wb_vld), .rbus_wb_preg(rbus_wb_preg), .rbus_wb_data(rbus_wb_data),
      .lsu_wb_vld(lsu_wb_vld), .lsu_wb_preg(lsu_wb_preg), .lsu_wb_data(lsu_wb_data),
      .req_vld(req_vld), .req_preg(req_preg), .req_data(req_data), .req_grnt(req_grnt),
      .wb0_vld(wb0_vld), .wb0_preg(wb0_preg), .wb0_data(wb0_data),
      .wb1_vld(wb1_vld), .wb1_preg(wb1_preg), .wb1_data(wb1_data),
      .rbus_stall(rbus_stall), .wb_no_op(wb_no_op)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model state: pending rbus result, pointer, starved-cycle run length
   logic          m_rq_vld;
   logic [PW-1:0] m_rq_preg;
   logic [DW-1:0] m_rq_data;
   int unsigned   m_ptr;
   int unsigned   m_run;
   logic          m_stall;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_check();
      int unsigned   q[$];
      int unsigned   g;
      logic [NR-1:0] e_g;
      logic          e0v, e1v, anyg, starving;
      logic [PW-1:0] e0p, e1p;
      logic [DW-1:0] e0d, e1d;
      e_g = '0; e0v = 1'b0; e1v = 1'b0; e0p = '0; e1p = '0; e0d = '0; e1d = '0;
      anyg = 1'b0;
      if (lsu_wb_vld) begin
         e1v = 1'b1; e1p = lsu_wb_preg; e1d = lsu_wb_data;
      end
      if (!cpurst_b) begin
         m_rq_vld = 1'b0; m_ptr = 0; m_run = 0; m_stall = 1'b0;
      end else begin
         for (int unsigned k = 0; k < NR; k++)
            if (req_vld[(m_ptr + k) % NR]) q.push_back((m_ptr + k) % NR);
         if (m_rq_vld) begin
            e0v = 1'b1; e0p = m_rq_preg; e0d = m_rq_data;
         end else if (q.size() > 0) begin
            g = q.pop_front();
            e_g[g] = 1'b1; anyg = 1'b1; m_ptr = (g + 1) % NR;
            e0v = 1'b1; e0p = req_preg[g*PW +: PW]; e0d = req_data[g*DW +: DW];
         end
         if (!lsu_wb_vld && q.size() > 0) begin
            g = q.pop_front();
            e_g[g] = 1'b1; anyg = 1'b1; m_ptr = (g + 1) % NR;
            e1v = 1'b1; e1p = req_preg[g*PW +: PW]; e1d = req_data[g*DW +: DW];
         end
      end
      chk("grant", 64'(req_grnt), 64'(e_g));
      chk("wb0_vld", 64'(wb0_vld), 64'(e0v));
      if (e0v) begin
         chk("wb0_preg", 64'(wb0_preg), 64'(e0p));
         chk("wb0_data", wb0_data, e0d);
      end
      chk("wb1_vld", 64'(wb1_vld), 64'(e1v));
      if (e1v) begin
         chk("wb1_preg", 64'(wb1_preg), 64'(e1p));
         chk("wb1_data", wb1_data, e1d);
      end
      chk("rbus_stall", 64'(rbus_stall), 64'(m_stall));
      chk("wb_no_op", 64'(wb_no_op), 64'(!(e0v || e1v)));
      if (cpurst_b) begin
         starving = (|req_vld) && !anyg;
         m_stall  = starving && (m_run >= LIM);
         m_run    = starving ? m_run + 1 : 0;
         m_rq_vld = rbus_wb_vld;
         if (rbus_wb_vld) begin
            m_rq_preg = rbus_wb_preg; m_rq_data = rbus_wb_data;
         end
      end
   endtask

   task automatic sample();
      @(negedge wb_clk);
      model_check();
   endtask

   task automatic adv();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic cyc();
      sample();
      adv();
   endtask

   initial begin
      cpurst_b = 1'b0;
      rbus_wb_vld = 1'b0; rbus_wb_preg = '0; rbus_wb_data = '0;
      lsu_wb_vld = 1'b0; lsu_wb_preg = '0; lsu_wb_data = '0;
      req_vld = '0;
      for (int i = 0; i < NR; i++) begin
         req_preg[i*PW +: PW] = PW'(8 + i);
         req_data[i*DW +: DW] = 64'h1000 + 64'(i);
      end
      m_rq_vld = 1'b0; m_rq_preg = '0; m_rq_data = '0; m_ptr = 0; m_run = 0; m_stall = 1'b0;
      adv();
      // reset state
      sample();
      chk("rst_wb0_vld", 64'(wb0_vld), 64'd0);
      chk("rst_no_op", 64'(wb_no_op), 64'd1);
      chk("rst_stall", 64'(rbus_stall), 64'd0);
      adv();
      cpurst_b = 1'b1;
      cyc();

      // rbus result appears on port0 one cycle later
      rbus_wb_vld = 1'b1; rbus_wb_preg = 6'd5; rbus_wb_data = 64'hA5;
      cyc();
      rbus_wb_vld = 1'b0;
      sample();
      chk("rbus_lat_vld", 64'(wb0_vld), 64'd1);
      chk("rbus_lat_preg", 64'(wb0_preg), 64'd5);
      chk("rbus_lat_data", wb0_data, 64'hA5);
      chk("rbus_lat_grnt", 64'(req_grnt), 64'd0);
      adv();

      // round robin over four requesters, two per cycle
      req_vld = 4'b1111;
      sample();
      chk("rr1", 64'(req_grnt), 64'b0011);
      chk("rr1_p0", 64'(wb0_preg), 64'd8);
      chk("rr1_p1", 64'(wb1_preg), 64'd9);
      adv();
      sample();
      chk("rr2", 64'(req_grnt), 64'b1100);
      adv();
      sample();
      chk("rr3", 64'(req_grnt), 64'b0011);
      adv();
      req_vld = '0;

      // both ports busy, then port1 frees up
      rbus_wb_vld = 1'b1; rbus_wb_preg = 6'd1; rbus_wb_data = 64'h11;
      cyc();
      lsu_wb_vld = 1'b1; lsu_wb_preg = 6'd7; lsu_wb_data = 64'h77; req_vld = 4'b0100;
      sample();
      chk("busy_grnt", 64'(req_grnt), 64'd0);
      chk("busy_wb0", 64'(wb0_vld), 64'd1);
      chk("busy_wb1_preg", 64'(wb1_preg), 64'd7);
      adv();
      rbus_wb_vld = 1'b0; lsu_wb_vld = 1'b0;
      sample();
      chk("p1_grnt", 64'(req_grnt), 64'b0100);
      chk("p1_preg", 64'(wb1_preg), 64'd10);
      chk("p1_wb0_rbus", 64'(wb0_preg), 64'd1);
      adv();
      req_vld = '0;

      // starvation raises rbus_stall
      rbus_wb_vld = 1'b1; lsu_wb_vld = 1'b1;
      cyc();
      req_vld = 4'b1000;
      for (int i = 1; i <= 12; i++) begin
         sample();
         chk("starve_grnt", 64'(req_grnt), 64'd0);
         if (i == 9)  chk("stall_pre", 64'(rbus_stall), 64'd0);
         if (i >= 10) chk("stall_on", 64'(rbus_stall), 64'd1);
         adv();
      end
      rbus_wb_vld = 1'b0;
      sample();
      chk("stall_hold", 64'(rbus_stall), 64'd1);
      adv();
      sample();
      chk("starve_release", 64'(req_grnt), 64'b1000);
      chk("starve_rel_preg", 64'(wb0_preg), 64'd11);
      adv();
      req_vld = '0;
      sample();
      chk("stall_off", 64'(rbus_stall), 64'd0);
      adv();
      lsu_wb_vld = 1'b0;

      // reset mid-operation with rbus pending and rr_ptr at 2
      req_vld = 4'b0011;
      sample();
      chk("pre_rst_grnt", 64'(req_grnt), 64'b0011);
      adv();
      req_vld = '0; rbus_wb_vld = 1'b1; rbus_wb_preg = 6'd3; rbus_wb_data = 64'h33;
      cyc();
      cpurst_b = 1'b0; rbus_wb_vld = 1'b0; req_vld = 4'b0100;
      sample();
      chk("mrst_wb0", 64'(wb0_vld), 64'd0);
      chk("mrst_no_op", 64'(wb_no_op), 64'd1);
      chk("mrst_stall", 64'(rbus_stall), 64'd0);
      chk("mrst_grnt", 64'(req_grnt), 64'd0);
      adv();
      cpurst_b = 1'b1; req_vld = 4'b1111;
      sample();
      chk("post_rst_grnt", 64'(req_grnt), 64'b0011);
      chk("post_rst_preg", 64'(wb0_preg), 64'd8);
      adv();
      req_vld = '0;
      cyc();

      // mixed traffic against the model
      for (int i = 0; i < 80; i++) begin
         req_vld      = NR'($urandom);
         rbus_wb_vld  = ($urandom_range(0, 3) != 0);
         rbus_wb_preg = PW'($urandom);
         rbus_wb_data = {32'($urandom), 32'($urandom)};
         lsu_wb_vld   = ($urandom_range(0, 2) != 0);
         lsu_wb_preg  = PW'($urandom);
         lsu_wb_data  = {32'($urandom), 32'($urandom)};
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
